// File: rtl/led_flash_sequencer.sv
// led_flash_sequencer: plays a timed win/fail blink sequence on 16 LEDs and drives the LED mux select.
module led_flash_sequencer #(
    parameter int          TICKS_PER_PHASE = 25_000_000,
    parameter int          NUM_BLINKS      = 3,
    parameter logic [15:0] WIN_PATTERN     = 16'hFFFF,
    parameter logic [15:0] FAIL_PATTERN    = 16'hAAAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_win,
    input  logic        req_fail,
    input  logic        cancel,
    output logic        flash,
    output logic [15:0] pattern,
    output logic        busy,
    output logic        is_fail,
    output logic        done
);
    localparam int PW = $clog2(TICKS_PER_PHASE + 1);
    localparam int BW = $clog2(NUM_BLINKS + 1);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    state_t state, state_n;
    logic [PW-1:0] phase_cnt, phase_cnt_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic is_fail_n, done_n, phase_end, last_blink;
    assign phase_end  = phase_cnt == PW'(TICKS_PER_PHASE - 1);
    assign last_blink = blink_cnt == BW'(NUM_BLINKS - 1);
    always_comb begin
        state_n     = state;
        phase_cnt_n = '0;
        blink_cnt_n = blink_cnt;
        is_fail_n   = is_fail;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                blink_cnt_n = '0;
                if (req_fail || req_win) begin
                    state_n   = ON;
                    is_fail_n = req_fail;
                end
            end
            ON: begin
                if (cancel) begin
                    state_n     = IDLE;
                    blink_cnt_n = '0;
                end else if (phase_end) state_n = OFF;
                else phase_cnt_n = phase_cnt + 1'b1;
            end
            OFF: begin
                if (cancel) begin
                    state_n     = IDLE;
                    blink_cnt_n = '0;
                end else if (phase_end) begin
                    state_n     = last_blink ? IDLE : ON;
                    blink_cnt_n = last_blink ? '0 : blink_cnt + 1'b1;
                    done_n      = last_blink;
                end else phase_cnt_n = phase_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            blink_cnt <= '0;
            flash     <= 1'b0;
            pattern   <= '0;
            busy      <= 1'b0;
            is_fail   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            phase_cnt <= phase_cnt_n;
            blink_cnt <= blink_cnt_n;
            flash     <= state_n != IDLE;
            pattern   <= state_n == ON ? (is_fail_n ? FAIL_PATTERN : WIN_PATTERN) : '0;
            busy      <= state_n != IDLE;
            is_fail   <= is_fail_n;
            done      <= done_n;
        end
    end
endmodule

// File: doc/led_flash_sequencer.md
Name: led_flash_sequencer

Overview:
- Drives the flash select and the flash pattern of the LED output multiplexer.
- On a win or fail event from the game FSM, it plays a timed blink sequence on the 16 LEDs, then hands the LEDs back to the normal game pattern.
- It arbitrates between the two event requesters. A sequence in progress is never pre-empted by a new request.

Parameters:
- TICKS_PER_PHASE, 25_000_000, clk cycles per on-phase and per off-phase (0.25 s at 100 MHz); must be >= 1
- NUM_BLINKS, 3, number of on/off pairs per sequence; must be >= 1
- WIN_PATTERN, 16'hFFFF, LED pattern shown in on-phases of a win sequence
- FAIL_PATTERN, 16'hAAAA, LED pattern shown in on-phases of a fail sequence

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_win  input  1  level/pulse request for a win sequence
- req_fail  input  1  level/pulse request for a fail sequence
- cancel  input  1  synchronous abort of a running sequence
- flash  output  1  mux select; 1 = LEDs show pattern, 0 = LEDs show game pattern
- pattern  output  16  flash pattern fed to the mux's alternate input
- busy  output  1  high while a sequence runs
- is_fail  output  1  type of the current or last sequence (1 = fail)
- done  output  1  one-cycle pulse when a sequence completes normally

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. All outputs are registered.
- Reset values: flash=0, pattern=16'h0000, busy=0, is_fail=0, done=0; state=IDLE; phase counter=0; blink counter=0.
- States: IDLE, ON, OFF.
- IDLE:
  - Requests are sampled only here.
  - If req_fail=1, go to ON with is_fail=1. This applies even if req_win=1 too: fail has priority.
  - Else if req_win=1, go to ON with is_fail=0.
  - Else stay in IDLE.
  - In IDLE: flash=0, pattern=0, busy=0.
- Latency: a request seen at edge k gives flash=1, busy=1, and pattern=selected pattern after edge k.
- ON:
  - flash=1, pattern=WIN_PATTERN or FAIL_PATTERN per is_fail.
  - Lasts exactly TICKS_PER_PHASE cycles, then goes to OFF.
- OFF:
  - flash=1, pattern=16'h0000 (LEDs dark, game pattern still masked).
  - Lasts exactly TICKS_PER_PHASE cycles.
  - The blink counter increments on leaving OFF.
  - If this was blink NUM_BLINKS, go to IDLE; else go to ON.
- Completion:
  - On the edge returning to IDLE from the final OFF, done=1 for exactly one cycle, with flash=0 and busy=0 in that same cycle.
  - Total busy duration = 2*NUM_BLINKS*TICKS_PER_PHASE cycles.
- Requests while busy (ON/OFF) are ignored, not queued.
  - A request held high through completion is accepted in the first IDLE cycle.
  - So back-to-back sequences have exactly one IDLE cycle between them.
- cancel=1 in ON or OFF:
  - Next edge: IDLE, flash=0, pattern=0, busy=0, done=0, counters cleared.
  - cancel in IDLE has no effect.
  - If cancel and a request are both high in IDLE, the request is accepted.
- reset has priority over cancel and requests. Reset mid-sequence behaves as reset at any time: all outputs at reset values after the edge.
- is_fail holds its value after the sequence ends until the next accepted request.
- Counter widths: phase counter is $clog2(TICKS_PER_PHASE+1) bits; blink counter is $clog2(NUM_BLINKS+1) bits. No wrap-around occurs within a sequence.

Test Plan:
All scenarios use TICKS_PER_PHASE=4, NUM_BLINKS=2.

1. Reset then idle: hold reset 2 cycles, no requests for 20 cycles -> flash=0, pattern=0, busy=0, done=0 throughout.
2. Win pulse: 1-cycle req_win -> next cycle flash=1, pattern=FFFF for 4 cycles, then 0000 for 4, FFFF for 4, 0000 for 4. After 16 busy cycles, done=1 for one cycle with flash=0; is_fail=0.
3. Simultaneous req_win and req_fail -> is_fail=1, on-phases show AAAA, 16 busy cycles, single done pulse.
4. req_win pulsed at busy cycle 5, then req_fail held high from cycle 10 -> the win pulse is ignored. The fail sequence starts one cycle after the first sequence's done (one IDLE cycle, done=1 in it); is_fail flips to 1.
5. cancel asserted in the second ON phase -> next cycle flash=0, pattern=0, busy=0; no done pulse. A req_win afterwards starts a full 16-cycle sequence.
6. reset asserted in an OFF phase -> all outputs at reset values after the edge, state IDLE. A subsequent req_fail runs a full sequence.
